// File: rtl/blowfish128_feistel.sv
// Blowfish-128 Feistel round controller: sequences P-array subkeys, drives the F-function unit
// and applies output whitening. Define BLOWFISH128_DECRYPT_EN to add the Decrypt port (reversed subkey order).
module blowfish128_feistel #(
   parameter int ROUNDS = 16,
   parameter int PIDX_W = 5
) (
   input  logic              Clk,
   input  logic              RstN,
   input  logic [127:0]      InData,
   input  logic              InValid,
   output logic              InReady,
   output logic [127:0]      OutData,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [PIDX_W-1:0] PIdx,
   input  logic [63:0]       PKey,
   output logic [63:0]       FX,
   output logic              FEnable,
   output logic              FClear,
   input  logic [63:0]       FY,
   input  logic              FValid
`ifdef BLOWFISH128_DECRYPT_EN
   ,
   input  logic              Decrypt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_XOR_P,
      S_F_WAIT,
      S_FIN0,
      S_FIN1,
      S_DONE
   } state_t;

   localparam logic [PIDX_W-1:0] LAST_ROUND = PIDX_W'(ROUNDS - 1);
   localparam logic [PIDX_W-1:0] FIN0_IDX   = PIDX_W'(ROUNDS);
   localparam logic [PIDX_W-1:0] FIN1_IDX   = PIDX_W'(ROUNDS + 1);

   state_t              state_q;
   logic [63:0]         l_q;
   logic [63:0]         r_q;
   logic [63:0]         fx_q;
   logic [127:0]        out_data_q;
   logic [PIDX_W-1:0]   round_q;
   logic [PIDX_W-1:0]   round_d;
   logic [PIDX_W-1:0]   pidx_q;
   logic                in_ready_q;
   logic                out_valid_q;
   logic                fenable_q;
   logic                fclear_q;
   logic                dec_q;
   logic                dec_start;

`ifdef BLOWFISH128_DECRYPT_EN
   assign dec_start = Decrypt;
`else
   assign dec_start = 1'b0;
`endif

   assign round_d = round_q + 1'b1;

   // Decrypt walks the P-array from the top: step i maps to index ROUNDS+1-i.
   function automatic logic [PIDX_W-1:0] key_idx(input logic [PIDX_W-1:0] step, input logic dec);
      return dec ? (FIN1_IDX - step) : step;
   endfunction

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state_q     <= S_IDLE;
         l_q         <= '0;
         r_q         <= '0;
         fx_q        <= '0;
         out_data_q  <= '0;
         round_q     <= '0;
         pidx_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         fenable_q   <= 1'b0;
         fclear_q    <= 1'b1;
         dec_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (InValid) begin
                  l_q        <= InData[127:64];
                  r_q        <= InData[63:0];
                  round_q    <= '0;
                  dec_q      <= dec_start;
                  pidx_q     <= key_idx('0, dec_start);
                  in_ready_q <= 1'b0;
                  state_q    <= S_XOR_P;
               end
            end
            S_XOR_P: begin
               l_q       <= l_q ^ PKey;
               fx_q      <= l_q ^ PKey;
               fenable_q <= 1'b1;
               fclear_q  <= 1'b0;
               state_q   <= S_F_WAIT;
            end
            S_F_WAIT: begin
               if (FValid) begin
                  l_q       <= r_q ^ FY;
                  r_q       <= l_q;
                  round_q   <= round_d;
                  pidx_q    <= key_idx(round_d, dec_q);
                  fenable_q <= 1'b0;
                  fclear_q  <= 1'b1;
                  state_q   <= (round_q == LAST_ROUND) ? S_FIN0 : S_XOR_P;
               end
            end
            S_FIN0: begin
               out_data_q[63:0] <= l_q ^ PKey;
               pidx_q           <= key_idx(FIN1_IDX, dec_q);
               state_q          <= S_FIN1;
            end
            S_FIN1: begin
               // Taking R for the upper half undoes the swap of the last round.
               out_data_q[127:64] <= r_q ^ PKey;
               out_valid_q        <= 1'b1;
               state_q            <= S_DONE;
            end
            S_DONE: begin
               if (OutReady) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign InReady  = in_ready_q;
   assign OutData  = out_data_q;
   assign OutValid = out_valid_q;
   assign PIdx     = pidx_q;
   assign FX       = fx_q;
   assign FEnable  = fenable_q;
   assign FClear   = fclear_q;

endmodule

// File: tb/tb_blowfish128_feistel.sv
// Randomized bench for blowfish128_feistel: F-unit and P-array models, a plain-loop Feistel reference,
// and a per-cycle compare process.
module tb_blowfish128_feistel;

   localparam int ROUNDS = 16;
   localparam int PIDX_W = 5;
   localparam logic [127:0] IDENT_IN  = 128'h0011223344556677_8899AABBCCDDEEFF;
   localparam logic [127:0] IDENT_OUT = 128'h8899AABBCCDDEEFF_0011223344556677;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [127:0]      in_data;
   logic              in_valid;
   logic              in_ready;
   logic [127:0]      out_data;
   logic              out_valid;
   logic              out_ready;
   logic [PIDX_W-1:0] pidx;
   logic [63:0]       p_key;
   logic [63:0]       fx;
   logic              f_enable;
   logic              f_clear;
   logic [63:0]       f_y;
   logic              f_valid;
   logic              dec_in;

   always #5 clk = ~clk;

   blowfish128_feistel #(.ROUNDS(ROUNDS), .PIDX_W(PIDX_W)) dut (
      .Clk(clk), .RstN(rst_n), .InData(in_data), .InValid(in_valid), .InReady(in_ready),
      .OutData(out_data), .OutValid(out_valid), .OutReady(out_ready), .PIdx(pidx), .PKey(p_key),
      .FX(fx), .FEnable(f_enable), .FClear(f_clear), .FY(f_y), .FValid(f_valid)
`ifdef BLOWFISH128_DECRYPT_EN
      , .Decrypt(dec_in)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- P-array and F-unit models ----------------
   logic [63:0] p_arr [32];
   bit  use_f;
   int  tf_fixed;
   bit  rand_lat;
   bit  glitch_en;
   bit  glitch_bit;
   int  cnt;
   int  cur_tf;

   function automatic logic [63:0] ffun(input logic [63:0] x);
      logic [63:0] m;
      m = x * 64'h9E3779B97F4A7C15;
      return {m[46:0], m[63:47]} ^ (x >> 7) ^ 64'h0123456789ABCDEF;
   endfunction

   function automatic logic [63:0] fmodel(input logic [63:0] x);
      return use_f ? ffun(x) : 64'h0;
   endfunction

   assign p_key = p_arr[pidx];
   assign f_y   = fmodel(fx);
   assign f_valid = (f_enable && !f_clear && (cnt == cur_tf - 1)) || (glitch_en && !f_enable && glitch_bit);

   always @(posedge clk) begin
      glitch_bit <= 1'($urandom_range(0, 1));
      if (f_clear) begin
         cnt    <= 0;
         cur_tf <= rand_lat ? int'($urandom_range(1, 9)) : tf_fixed;
      end else if (f_enable) begin
         cnt <= cnt + 1;
      end
   end

   // ---------------- reference model ----------------
   logic [127:0] exp_out_q[$];
   logic [63:0]  exp_fx_q[$];

   task automatic run_model(input logic [127:0] din, input bit dec, output logic [127:0] dout);
      logic [63:0] l, r, t;
      int k;
      l = din[127:64];
      r = din[63:0];
      for (int i = 0; i < ROUNDS; i++) begin
         k = dec ? (ROUNDS + 1 - i) : i;
         l = l ^ p_arr[k];
         exp_fx_q.push_back(l);
         r = r ^ fmodel(l);
         t = l; l = r; r = t;
      end
      t = l; l = r; r = t;
      r = r ^ p_arr[dec ? 1 : ROUNDS];
      l = l ^ p_arr[dec ? 0 : ROUNDS + 1];
      dout = {l, r};
   endtask

   // ---------------- per-cycle compare ----------------
   bit          fen_prev;
   logic [63:0] fx_prev;

   always @(negedge clk) begin
      if (!rst_n) begin
         fen_prev = 1'b0;
      end else begin
         chk("fclear_vs_fenable", 128'(f_clear), 128'(!f_enable));
         if (f_enable && !fen_prev) begin
            if (exp_fx_q.size() == 0) chk("fx_unexpected_round", 128'(1), 128'(0));
            else chk("fx_round", 128'(fx), 128'(exp_fx_q.pop_front()));
         end else if (f_enable) begin
            chk("fx_stable", 128'(fx), 128'(fx_prev));
         end
         if (out_valid) begin
            chk("inready_in_done", 128'(in_ready), 128'(0));
            if (exp_out_q.size() == 0) chk("outvalid_unexpected", 128'(1), 128'(0));
            else begin
               chk("outdata", out_data, exp_out_q[0]);
               if (out_ready) void'(exp_out_q.pop_front());
            end
         end
         fen_prev = f_enable;
         fx_prev  = fx;
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [PIDX_W-1:0] pidx_seq[$];
   logic [63:0]       first_fx;

   task automatic accept(input logic [127:0] din, input bit d, output logic [127:0] e);
      int n = 0;
      while (!in_ready && n < 5000) begin
         @(posedge clk); #2;
         n++;
      end
      if (!in_ready) begin
         $display("FAIL inready_timeout actual=0 required=1");
         $fatal(1, "timeout");
      end
      in_data  = din;
      dec_in   = d;
      in_valid = 1'b1;
      run_model(din, d, e);
      exp_out_q.push_back(e);
      pidx_seq.delete();
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int exp_lat);
      int  n = 1;
      bit  got_fx = 0;
      forever begin
         @(negedge clk);
         if (pidx_seq.size() == 0 || pidx != pidx_seq[$]) pidx_seq.push_back(pidx);
         if (f_enable && !got_fx) begin
            first_fx = fx;
            got_fx = 1;
         end
         if (out_valid) break;
         @(posedge clk);
         n++;
         if (n > 5000) begin
            $display("FAIL outvalid_timeout actual=%0d required=%0d", n, exp_lat);
            $fatal(1, "timeout");
         end
      end
      if (exp_lat > 0) chk("latency", 128'(n), 128'(exp_lat));
      @(posedge clk); #2;
   endtask

   task automatic check_reset_outputs();
      chk("rst_inready", 128'(in_ready), 128'(1));
      chk("rst_outvalid", 128'(out_valid), 128'(0));
      chk("rst_outdata", out_data, 128'(0));
      chk("rst_fenable", 128'(f_enable), 128'(0));
      chk("rst_fclear", 128'(f_clear), 128'(1));
      chk("rst_pidx", 128'(pidx), 128'(0));
      chk("rst_fx", 128'(fx), 128'(0));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [127:0] e, ct, din;
      int rises;
      bit prev;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; dec_in = 1'b0;
      use_f = 0; tf_fixed = 3; rand_lat = 0; glitch_en = 0;
      for (int i = 0; i < 32; i++) p_arr[i] = 64'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;

      // Identity pass-through
      accept(IDENT_IN, 0, e);
      chk("model_identity", e, IDENT_OUT);
      wait_out(1 + ROUNDS * (1 + 3) + 2);
      chk("identity_out_literal", out_data, IDENT_OUT);

      // Subkey sequencing
      for (int i = 0; i < 32; i++) p_arr[i] = 64'(i) * 64'h0101010101010101;
      din = {$urandom, $urandom, $urandom, $urandom};
      accept(din, 0, e);
      wait_out(1 + ROUNDS * 4 + 2);
      chk("first_fx", 128'(first_fx), 128'(din[127:64]));
      chk("pidx_seq_len", 128'(pidx_seq.size()), 128'(ROUNDS + 2));
      for (int i = 0; i < pidx_seq.size() && i < ROUNDS + 2; i++)
         chk($sformatf("pidx_seq[%0d]", i), 128'(pidx_seq[i]), 128'(i));

      // Golden: random P, real F, Tf=7
      for (int i = 0; i < 32; i++) p_arr[i] = {$urandom, $urandom};
      use_f = 1; tf_fixed = 7;
      for (int b = 0; b < 100; b++) begin
         accept({$urandom, $urandom, $urandom, $urandom}, 0, e);
         wait_out(1 + ROUNDS * 8 + 2);
      end

      // Backpressure with InValid attempts during DONE
      out_ready = 1'b0;
      accept({$urandom, $urandom, $urandom, $urandom}, 0, e);
      wait_out(1 + ROUNDS * 8 + 2);
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #2;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      chk("after_bp_idle_inready", 128'(in_ready), 128'(1));

      // Variable F latency and stray FValid outside F_WAIT
      rand_lat = 1; glitch_en = 1;
      for (int b = 0; b < 10; b++) begin
         accept({$urandom, $urandom, $urandom, $urandom}, 0, e);
         wait_out(-1);
      end
      rand_lat = 0; glitch_en = 0;

      // Reset during round 7 F_WAIT
      accept({$urandom, $urandom, $urandom, $urandom}, 0, e);
      rises = 0; prev = 0;
      for (int c = 0; c < 5000 && rises < 8; c++) begin
         @(negedge clk);
         if (f_enable && !prev) rises++;
         prev = f_enable;
      end
      chk("reached_round7", 128'(rises), 128'(8));
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      exp_out_q.delete();
      exp_fx_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;
      accept({$urandom, $urandom, $urandom, $urandom}, 0, e);
      wait_out(1 + ROUNDS * 8 + 2);

`ifdef BLOWFISH128_DECRYPT_EN
      din = {$urandom, $urandom, $urandom, $urandom};
      accept(din, 0, ct);
      wait_out(1 + ROUNDS * 8 + 2);
      accept(ct, 1, e);
      chk("model_roundtrip", e, din);
      wait_out(1 + ROUNDS * 8 + 2);
      chk("decrypt_recovers", out_data, din);
      chk("dec_pidx_seq_len", 128'(pidx_seq.size()), 128'(ROUNDS + 2));
      for (int i = 0; i < pidx_seq.size() && i < ROUNDS + 2; i++)
         chk($sformatf("dec_pidx_seq[%0d]", i), 128'(pidx_seq[i]), 128'(ROUNDS + 1 - i));
`endif

      repeat (3) @(posedge clk);
      chk("out_queue_drained", 128'(exp_out_q.size()), 128'(0));
      chk("fx_queue_drained", 128'(exp_fx_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/blowfish128_feistel.md
Name: blowfish128_feistel

Overview:
- Round controller for the Blowfish-128 datapath. It accepts a 128-bit block and runs ROUNDS Feistel rounds over 64-bit halves.
- Each round it XORs the left half with a P-array subkey, hands that half to the F-function unit, waits for the F result, and XORs it into the right half before swapping.
- Sits directly upstream of, and consumes results from, the F-function unit.
- Reads subkeys from the key-schedule register file and presents the output whitening result to the IP top.

Parameters:
- ROUNDS, 16, number of Feistel rounds; P-array depth is ROUNDS+2.
- PIDX_W, 5, subkey index width; must satisfy 2^PIDX_W >= ROUNDS+2.

Ports:
- Clk  in  1  clock, rising edge.
- RstN  in  1  asynchronous active-low reset.
- InData  in  128  plaintext block; [127:64]=L, [63:0]=R.
- InValid  in  1  InData valid.
- InReady  out  1  block can accept InData.
- OutData  out  128  result block.
- OutValid  out  1  OutData valid.
- OutReady  in  1  downstream accepts OutData.
- PIdx  out  PIDX_W  subkey index, registered.
- PKey  in  64  subkey P[PIdx]; combinational read, valid in the same cycle as PIdx.
- FX  out  64  F-function input, registered.
- FEnable  out  1  F-function enable.
- FClear  out  1  F-function clear; integration drives F RstN = RstN & ~FClear.
- FY  in  64  F-function result.
- FValid  in  1  F-function result valid.

Behaviour:
- Reset values: all registers 0, state IDLE, InReady=1, OutValid=0, OutData=0, FEnable=0, FClear=1, PIdx=0, FX=0. Reset is honoured mid-operation: any block in flight is discarded with no output.
- States: IDLE, XOR_P, F_WAIT, FIN0, FIN1, DONE.
- IDLE:
  - InReady=1.
  - On InValid: latch L, R; round=0; PIdx=0; go to XOR_P.
- XOR_P (1 cycle):
  - L <= L ^ PKey; FX <= L ^ PKey.
  - Go to F_WAIT.
- F_WAIT:
  - FEnable=1, FClear=0; FX held stable.
  - Stay in F_WAIT until FValid=1.
  - On the FValid cycle: L <= R ^ FY; R <= L (swap); round++; PIdx++.
  - If round was ROUNDS-1, go to FIN0; else go to XOR_P.
- FClear=1 and FEnable=0 in every state except F_WAIT. The F unit therefore restarts cleanly each round, and stale FValid from a previous round is never observed.
- FValid outside F_WAIT is ignored.
- Output whitening:
  - FIN0: PIdx=ROUNDS; OutData[63:0] <= L ^ PKey.
  - FIN1: PIdx=ROUNDS+1; OutData[127:64] <= R ^ PKey. This undoes the final swap.
  - Go to DONE.
- DONE:
  - OutValid=1; OutData held stable until OutReady=1.
  - On OutValid & OutReady: go to IDLE; OutValid drops in the next cycle.
  - InReady=0, so InValid is ignored in this state.
- Latency: with Tf = F_WAIT cycles per round including the FValid cycle, accept-to-OutValid = 1 + ROUNDS*(1+Tf) + 2 cycles.
- Widths: all XOR operations are 64-bit with no carries. The round counter is PIDX_W bits and never wraps within a block.
- One block in flight; no internal buffering.

Optional Feature:
- Macro: BLOWFISH128_DECRYPT_EN.
- Defined:
  - Adds input port Decrypt (1 bit), sampled on acceptance in IDLE and held for the whole block.
  - When Decrypt=1, the subkey index presented is ROUNDS+1-i in place of i. Rounds use P[17] down to P[2]; FIN0 uses P[1] and FIN1 uses P[0].
  - Dataflow is unchanged.
- Undefined: no Decrypt port; encrypt ordering only.

Test Plan:
- Identity pass-through: all P=0, F model returns 0 with Tf=3; InData=0x0011223344556677_8899AABBCCDDEEFF -> OutData=0x8899AABBCCDDEEFF_0011223344556677; OutValid exactly 1+16*4+2=67 cycles after acceptance.
- Subkey sequencing: PIdx observed over one block = 0..15, then 16, 17. FClear is low only during F_WAIT. The first FX equals L^P[0] with P[i]=i*0x0101010101010101.
- Golden check: random P, F model implementing the real F-function (Tf=7), 100 random blocks -> OutData matches the C reference encryption.
- Backpressure and F latency: OutReady held low for 10 cycles -> OutData stable and InReady=0; then F latency varied per round (1..9) -> result unchanged; FValid pulsed in XOR_P -> ignored.
- Reset mid-round: RstN asserted during round 7 F_WAIT -> all outputs at reset values immediately; the next block processes correctly from IDLE.
- Decrypt (macro on): encrypt then decrypt the same block with the same P -> original InData recovered; PIdx sequence 17..2, then 1, 0.
